// File: rtl/uart_cmd_pkg.sv
// Shared constants for the UART command decoder: sync marker default,
// FSM state encodings and error codes.
package uart_cmd_pkg;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  typedef logic [1:0] state_t;
  localparam state_t S_IDLE = 2'd0;
  localparam state_t S_ADDR = 2'd1;
  localparam state_t S_DATA = 2'd2;
  localparam state_t S_CHK  = 2'd3;

  typedef logic [1:0] err_t;
  localparam err_t ERR_NONE    = 2'd0;
  localparam err_t ERR_CHK     = 2'd1;
  localparam err_t ERR_TIMEOUT = 2'd2;
  localparam err_t ERR_OVERRUN = 2'd3;

endpackage

// File: rtl/uart_byte_strobe.sv
// Rising-edge detector on rx_ready; registers the strobe together with the byte.
module uart_byte_strobe (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_ready,
  input  logic [7:0] rx_data,
  output logic       byte_stb_p0,
  output logic [7:0] byte_data_p0
);

  logic rx_ready_q;

  // stage p0: the history bit resets high so a level already present at release is not a new byte
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_ready_q  <= 1'b1;
      byte_stb_p0 <= 1'b0;
    end else begin
      rx_ready_q  <= rx_ready;
      byte_stb_p0 <= rx_ready & ~rx_ready_q;
    end
  end

  always_ff @(posedge clk) begin
    byte_data_p0 <= rx_data;
  end

endmodule

// File: rtl/uart_cmd_decoder.sv
// Parses SYNC/ADDR/WDATA/CHK write frames from the UART byte stream and
// presents one decoded command at a time on a valid/ready output register.
module uart_cmd_decoder
  import uart_cmd_pkg::*;
#(
  parameter int         ADDR_BYTES   = 2,
  parameter int         WDATA_BYTES  = 1,
  parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEFAULT,
  parameter int         TIMEOUT_CLKS = 2048
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rx_ready,
  input  logic [7:0]               rx_data,
  output logic                     cmd_valid,
  input  logic                     cmd_ready,
  output logic [8*ADDR_BYTES-1:0]  cmd_addr,
  output logic [8*WDATA_BYTES-1:0] cmd_wdata,
  output logic                     chk_err,
  output logic                     timeout_err,
  output logic                     overrun_err
);

  localparam int AW    = 8 * ADDR_BYTES;
  localparam int DW    = 8 * WDATA_BYTES;
  localparam int CNT_W = $clog2((ADDR_BYTES > WDATA_BYTES) ? ADDR_BYTES : WDATA_BYTES) + 1;
  localparam int TW    = $clog2(TIMEOUT_CLKS);

  logic             vld_p0;
  logic [7:0]       byte_p0;
  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [7:0]       chk;
  logic [TW-1:0]    tcnt;
  logic [AW-1:0]    addr_sh;
  logic [DW-1:0]    wdata_sh;
  err_t             err_code;
  logic             load;

  uart_byte_strobe u_strobe (
    .clk          (clk),
    .rst          (rst),
    .rx_ready     (rx_ready),
    .rx_data      (rx_data),
    .byte_stb_p0  (vld_p0),
    .byte_data_p0 (byte_p0)
  );

  // A checksum failure takes priority; only a good frame can overrun or load.
  always_comb begin
    err_code = ERR_NONE;
    load     = 1'b0;
    if (vld_p0 && state == S_CHK) begin
      if (byte_p0 != chk)
        err_code = ERR_CHK;
      else if (cmd_valid && !cmd_ready)
        err_code = ERR_OVERRUN;
      else
        load = 1'b1;
    end else if (state != S_IDLE && !vld_p0 && tcnt == TW'(TIMEOUT_CLKS - 1)) begin
      err_code = ERR_TIMEOUT;
    end
  end

  // stage p1: FSM, checksum, timeout and output register
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      chk         <= '0;
      tcnt        <= '0;
      cmd_valid   <= 1'b0;
      cmd_addr    <= '0;
      cmd_wdata   <= '0;
      chk_err     <= 1'b0;
      timeout_err <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      chk_err     <= (err_code == ERR_CHK);
      timeout_err <= (err_code == ERR_TIMEOUT);
      overrun_err <= (err_code == ERR_OVERRUN);

      if (load) begin
        cmd_valid <= 1'b1;
        cmd_addr  <= addr_sh;
        cmd_wdata <= wdata_sh;
      end else if (cmd_valid && cmd_ready) begin
        cmd_valid <= 1'b0;
      end

      if (state == S_IDLE || vld_p0 || err_code == ERR_TIMEOUT)
        tcnt <= '0;
      else
        tcnt <= tcnt + 1'b1;

      if (err_code == ERR_TIMEOUT) begin
        state <= S_IDLE;
      end else if (vld_p0) begin
        case (state)
          S_IDLE: begin
            if (byte_p0 == SYNC_BYTE) begin
              state <= S_ADDR;
              cnt   <= '0;
              chk   <= '0;
            end
          end
          S_ADDR: begin
            chk <= chk ^ byte_p0;
            if (cnt == CNT_W'(ADDR_BYTES - 1)) begin
              state <= S_DATA;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          S_DATA: begin
            chk <= chk ^ byte_p0;
            if (cnt == CNT_W'(WDATA_BYTES - 1))
              state <= S_CHK;
            else
              cnt <= cnt + 1'b1;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (vld_p0 && state == S_ADDR)
      addr_sh <= AW'({addr_sh, byte_p0});
    if (vld_p0 && state == S_DATA)
      wdata_sh <= DW'({wdata_sh, byte_p0});
  end

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Bench for uart_cmd_decoder: frame table, directed corner sequences and a
// random byte stream, all cross-checked every clock against a frame-level model.
module tb_uart_cmd_decoder;

  localparam int T = 2048;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_ready = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        cmd_ready = 1'b0;
  logic        cmd_valid, chk_err, timeout_err, overrun_err;
  logic [15:0] cmd_addr;
  logic [7:0]  cmd_wdata;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  uart_cmd_decoder #(
    .ADDR_BYTES(2), .WDATA_BYTES(1), .SYNC_BYTE(8'hA5), .TIMEOUT_CLKS(T)
  ) dut (
    .clk(clk), .rst(rst), .rx_ready(rx_ready), .rx_data(rx_data),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata), .chk_err(chk_err), .timeout_err(timeout_err),
    .overrun_err(overrun_err)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Observed traffic, sampled at the edge the DUT itself samples
  int          n_cmd = 0, n_chk = 0, n_to = 0, n_ov = 0;
  logic [15:0] last_addr = '0;
  logic [7:0]  last_wd = '0;

  // Frame-level reference model
  bit          armed = 0;
  bit          m_prev = 1, m_pend = 0, m_inframe = 0;
  logic [7:0]  m_pbyte = '0;
  logic [7:0]  m_frm[$];
  int          m_gap = 0;
  bit          m_valid = 0, e_chk = 0, e_to = 0, e_ov = 0;
  logic [15:0] m_addr = '0;
  logic [7:0]  m_wdata = '0;

  always @(posedge clk) begin
    bit hs, done;
    if (cmd_valid === 1'b1 && cmd_ready) begin
      n_cmd++;
      last_addr = cmd_addr;
      last_wd   = cmd_wdata;
    end
    if (chk_err === 1'b1) n_chk++;
    if (timeout_err === 1'b1) n_to++;
    if (overrun_err === 1'b1) n_ov++;

    e_chk = 0; e_to = 0; e_ov = 0;
    if (rst) begin
      armed = 1; m_prev = 1; m_pend = 0; m_inframe = 0; m_gap = 0;
      m_frm.delete();
      m_valid = 0; m_addr = '0; m_wdata = '0;
    end else begin
      hs = m_valid && cmd_ready;
      done = 0;
      if (m_pend) begin
        m_gap = 0;
        if (!m_inframe) begin
          if (m_pbyte == 8'hA5) begin
            m_inframe = 1;
            m_frm.delete();
          end
        end else begin
          m_frm.push_back(m_pbyte);
          if (m_frm.size() == 4) begin
            done = 1;
            m_inframe = 0;
          end
        end
      end else if (m_inframe) begin
        m_gap++;
        if (m_gap == T) begin
          e_to = 1;
          m_inframe = 0;
        end
      end
      if (done) begin
        if ((m_frm[0] ^ m_frm[1] ^ m_frm[2]) != m_frm[3]) e_chk = 1;
        else if (m_valid && !hs) e_ov = 1;
        else begin
          m_valid = 1;
          m_addr  = {m_frm[0], m_frm[1]};
          m_wdata = m_frm[2];
          hs = 0;
        end
      end
      if (hs) m_valid = 0;
      m_pend  = rx_ready && !m_prev;
      m_pbyte = rx_data;
      m_prev  = rx_ready;
    end
    #1;
    if (armed)
      check("cycle", {4'h0, cmd_valid, chk_err, timeout_err, overrun_err, cmd_addr, cmd_wdata},
                     {4'h0, m_valid, e_chk, e_to, e_ov, m_addr, m_wdata});
  end

  bit rnd = 0;

  task automatic tick();
    @(negedge clk);
    if (rnd) cmd_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    tick();
    rx_ready = 1'b1;
    rx_data  = b;
    tick();
    rx_ready = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic send_bytes(input logic [55:0] bytes, input int n, input int gap);
    for (int i = 0; i < n; i++) send_byte(bytes[55 - 8*i -: 8], gap);
  endtask

  typedef struct {
    logic [55:0] bytes;
    int          n;
    int          ncmd;
    logic [15:0] addr;
    logic [7:0]  wd;
    int          nchk;
  } vec_t;

  vec_t tbl[5];

  initial begin
    int s_cmd, s_chk, s_to, s_ov;

    tbl[0] = '{56'hA5_12_34_5C_7A_00_00, 5, 1, 16'h1234, 8'h5C, 0};
    tbl[1] = '{56'h00_FF_A5_12_34_5C_7B, 7, 0, 16'h0000, 8'h00, 1};
    tbl[2] = '{56'hA5_AB_CD_01_67_00_00, 5, 1, 16'hABCD, 8'h01, 0};
    tbl[3] = '{56'hA5_A5_A5_A5_A5_00_00, 5, 1, 16'hA5A5, 8'hA5, 0};
    tbl[4] = '{56'hA5_FF_00_0F_F0_00_00, 5, 1, 16'hFF00, 8'h0F, 0};

    repeat (3) @(negedge clk);
    check("reset_state", {cmd_valid, chk_err, timeout_err, overrun_err, cmd_addr, cmd_wdata}, '0);
    rst = 1'b0;

    cmd_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      s_cmd = n_cmd; s_chk = n_chk; s_to = n_to; s_ov = n_ov;
      send_bytes(tbl[i].bytes, tbl[i].n, i % 3);
      repeat (6) @(negedge clk);
      check("tbl_ncmd", n_cmd - s_cmd, tbl[i].ncmd);
      if (tbl[i].ncmd > 0) begin
        check("tbl_addr", last_addr, tbl[i].addr);
        check("tbl_wdata", last_wd, tbl[i].wd);
      end
      check("tbl_nchk", n_chk - s_chk, tbl[i].nchk);
      check("tbl_noerr", (n_to - s_to) + (n_ov - s_ov), 0);
      check("tbl_idle_valid", cmd_valid, 1'b0);
    end

    // Inter-byte timeout, then recovery with a clean frame
    s_to = n_to; s_cmd = n_cmd;
    send_bytes(56'hA5_12_00_00_00_00_00, 2, 0);
    repeat (T + 4) @(negedge clk);
    check("timeout_pulse", n_to - s_to, 1);
    send_bytes(56'hA5_AB_CD_01_67_00_00, 5, 1);
    repeat (6) @(negedge clk);
    check("timeout_recover_n", n_cmd - s_cmd, 1);
    check("timeout_recover_addr", last_addr, 16'hABCD);
    check("timeout_recover_wd", last_wd, 8'h01);

    // Overrun: second frame arrives while the first is still held
    cmd_ready = 1'b0;
    s_ov = n_ov; s_cmd = n_cmd;
    send_bytes(56'hA5_00_01_02_03_00_00, 5, 1);
    send_bytes(56'hA5_00_02_03_01_00_00, 5, 1);
    repeat (4) @(negedge clk);
    check("ovr_pulse", n_ov - s_ov, 1);
    check("ovr_held", {cmd_valid, cmd_addr, cmd_wdata}, {1'b1, 16'h0001, 8'h02});
    cmd_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("ovr_consumed_n", n_cmd - s_cmd, 1);
    check("ovr_consumed_addr", last_addr, 16'h0001);
    check("ovr_drained", cmd_valid, 1'b0);

    // Load in the same cycle as the handshake of the pending command
    cmd_ready = 1'b0;
    s_ov = n_ov; s_cmd = n_cmd;
    send_bytes(56'hA5_12_34_5C_7A_00_00, 5, 1);
    send_bytes(56'hA5_AB_CD_01_00_00_00, 4, 1);
    @(negedge clk);
    rx_ready = 1'b1; rx_data = 8'h67;
    @(negedge clk);
    rx_ready = 1'b0; cmd_ready = 1'b1;
    @(negedge clk);
    cmd_ready = 1'b0;
    check("swap_valid", cmd_valid, 1'b1);
    check("swap_new_cmd", {cmd_addr, cmd_wdata}, {16'hABCD, 8'h01});
    check("swap_old_taken", last_addr, 16'h1234);
    check("swap_no_overrun", n_ov - s_ov, 0);
    cmd_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("swap_drain_n", n_cmd - s_cmd, 2);
    check("swap_drain_addr", last_addr, 16'hABCD);

    // Reset mid-frame with a pending command and rx_ready held high
    cmd_ready = 1'b0;
    send_bytes(56'hA5_12_34_5C_7A_00_00, 5, 1);
    repeat (3) @(negedge clk);
    check("rst_pending_before", cmd_valid, 1'b1);
    send_bytes(56'hA5_12_00_00_00_00_00, 2, 0);
    @(negedge clk);
    rx_ready = 1'b1; rx_data = 8'h34; rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_cleared", {cmd_valid, chk_err, timeout_err, overrun_err, cmd_addr, cmd_wdata}, '0);
    rx_ready = 1'b0; cmd_ready = 1'b1;
    s_cmd = n_cmd; s_chk = n_chk;
    send_bytes(56'hA5_12_34_5C_7A_00_00, 5, 1);
    repeat (6) @(negedge clk);
    check("rst_next_n", n_cmd - s_cmd, 1);
    check("rst_next_cmd", {last_addr, last_wd}, {16'h1234, 8'h5C});
    check("rst_no_chk", n_chk - s_chk, 0);

    // Random stream: junk, good frames, corrupted frames, random backpressure
    rnd = 1;
    for (int f = 0; f < 60; f++) begin
      int          kind;
      int          gap;
      logic [15:0] a;
      logic [7:0]  d, c;
      kind = $urandom_range(0, 3);
      gap  = $urandom_range(0, 4);
      a = 16'($urandom);
      d = 8'($urandom);
      c = a[15:8] ^ a[7:0] ^ d;
      if (kind == 0) begin
        send_byte(8'($urandom), gap);
      end else begin
        if (kind == 1) c = c ^ (8'h01 << $urandom_range(0, 7));
        send_bytes({8'hA5, a, d, c, 16'h0000}, 5, gap);
      end
    end
    rnd = 0;
    cmd_ready = 1'b1;
    repeat (8) @(negedge clk);
    check("rand_drained", cmd_valid, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
